// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execute-stage ALU; logic/arith ops finish in one clock,
// shifts iterate one bit per clock under a small IDLE/SHIFT/DONE FSM.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [2:0]       aluControl,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             lessThan
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] aluRes;
    logic [WIDTH-1:0] shiftNext;
    logic [SW-1:0]    count;
    logic [SW-1:0]    shamt;
    logic             shiftLeft;
    logic             signedLess;

    assign inReady    = state == IDLE;
    assign shamt      = srcB[SW-1:0];
    assign signedLess = $signed(srcA) < $signed(srcB);
    assign shiftNext  = shiftLeft ? work << 1 : work >> 1;

    // Shift codes produce no single-cycle result; the FSM owns them.
    always_comb begin
        case (aluControl)
            3'b000:         aluRes = srcA + srcB;
            3'b001, 3'b100: aluRes = srcA - srcB;
            3'b010:         aluRes = srcA & srcB;
            3'b011:         aluRes = srcA | srcB;
            3'b101:         aluRes = {{(WIDTH-1){1'b0}}, signedLess};
            default:        aluRes = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            outValid  <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            lessThan  <= 1'b0;
            count     <= '0;
            work      <= '0;
            shiftLeft <= 1'b0;
        end else begin
            case (state)
                IDLE: if (inValid) begin
                    lessThan <= signedLess;
                    if (aluControl[2:1] == 2'b11) begin
                        work      <= srcA;
                        count     <= shamt;
                        shiftLeft <= ~aluControl[0];
                        if (shamt == '0) begin
                            result   <= srcA;
                            zero     <= srcA == '0;
                            outValid <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end else begin
                        result   <= aluRes;
                        zero     <= aluRes == '0;
                        outValid <= 1'b1;
                        state    <= DONE;
                    end
                end
                SHIFT: begin
                    work  <= shiftNext;
                    count <= count - 1'b1;
                    if (count == SW'(1)) begin
                        result   <= shiftNext;
                        zero     <= shiftNext == '0;
                        outValid <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: if (outReady) begin
                    outValid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard-driven bench; each op's expected result and latency
// are pushed when issued and popped when the unit presents its output.
module tb_alu_exec_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         inValid = 1'b0;
    logic         outReady = 1'b0;
    logic [2:0]   aluControl = 3'b000;
    logic [W-1:0] srcA = '0;
    logic [W-1:0] srcB = '0;
    logic         inReady;
    logic         outValid;
    logic [W-1:0] result;
    logic         zero;
    logic         lessThan;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         lt;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .aluControl(aluControl), .srcA(srcA), .srcB(srcB),
        .outValid(outValid), .outReady(outReady),
        .result(result), .zero(zero), .lessThan(lessThan)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(logic [2:0] c, logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        int   sh;
        sh = int'(b[4:0]);
        case (c)
            3'd0: e.res = a + b;
            3'd1: e.res = a - b;
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: e.res = a - b;
            3'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: e.res = a << sh;
            default: e.res = a >> sh;
        endcase
        e.z   = e.res == '0;
        e.lt  = $signed(a) < $signed(b);
        e.lat = (c[2:1] == 2'b11) ? sh + 1 : 1;
        return e;
    endfunction

    // Issues an op, waits for the accepting edge, and leaves time at accept edge + 1.
    task automatic send(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        aluControl = c;
        srcA = a;
        srcB = b;
        inValid = 1'b1;
        sb.push_back(model(c, a, b));
        while (!inReady && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    // Counts clocks from accept until outValid; optionally scrambles inputs meanwhile.
    task automatic waitOut(input bit scramble, output int lat);
        lat = 1;
        while (!outValid && lat < 200) begin
            if (scramble) begin
                srcA = $urandom;
                srcB = $urandom;
                aluControl = 3'($urandom_range(0, 7));
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({outValid, result, zero, lessThan, inReady} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset: got ov=%b res=%h z=%b lt=%b ir=%b, want 0 0 0 0 1",
                     outValid, result, zero, lessThan, inReady);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_add;
        exp_t e;
        int   lat;
        outReady = 1'b1;
        send(3'd0, 32'd5, 32'd7);
        waitOut(1'b0, lat);
        e = sb.pop_front();
        total++;
        if (lat !== e.lat) $display("FAIL add latency: got %0d want %0d", lat, e.lat);
        else passed++;
        total++;
        if ({result, zero} !== {e.res, e.z}) $display("FAIL add result: got %h z=%b want %h z=%b", result, zero, e.res, e.z);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if ({inReady, outValid} !== 2'b10) $display("FAIL add retire: got ir=%b ov=%b want 1 0", inReady, outValid);
        else passed++;
    endtask

    task automatic test_arith;
        logic [2:0]   c[4] = '{3'd4, 3'd5, 3'd1, 3'd2};
        logic [W-1:0] a[4] = '{32'h1234, 32'hFFFF_FFFF, 32'd3, 32'hF0F0_1234};
        logic [W-1:0] b[4] = '{32'h1234, 32'd1, 32'd5, 32'h0FF0_0004};
        exp_t e;
        int   lat;
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(c[i], a[i], b[i]);
            waitOut(1'b0, lat);
            e = sb.pop_front();
            total++;
            if ({lat == e.lat, result, zero, lessThan} !== {1'b1, e.res, e.z, e.lt})
                $display("FAIL arith op%0d: got lat=%0d res=%h z=%b lt=%b want lat=%0d res=%h z=%b lt=%b",
                         c[i], lat, result, zero, lessThan, e.lat, e.res, e.z, e.lt);
            else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_shift_latency;
        logic [2:0]   c[4] = '{3'd6, 3'd7, 3'd6, 3'd7};
        logic [W-1:0] a[4] = '{32'd1, 32'h8000_0000, 32'hABCD_0001, 32'hFFFF_FFFF};
        logic [W-1:0] b[4] = '{32'd31, 32'd4, 32'h20, 32'd31};
        exp_t e;
        int   lat;
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(c[i], a[i], b[i]);
            waitOut(1'b0, lat);
            e = sb.pop_front();
            total++;
            if (lat !== e.lat) $display("FAIL shift%0d latency: got %0d want %0d", i, lat, e.lat);
            else passed++;
            total++;
            if ({result, zero, lessThan} !== {e.res, e.z, e.lt})
                $display("FAIL shift%0d result: got %h z=%b lt=%b want %h z=%b lt=%b",
                         i, result, zero, lessThan, e.res, e.z, e.lt);
            else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        int   lat;
        outReady = 1'b0;
        send(3'd3, 32'hF0, 32'h0F);
        waitOut(1'b0, lat);
        e = sb.pop_front();
        total++;
        if ({lat == e.lat, result} !== {1'b1, e.res}) $display("FAIL bp result: got lat=%0d res=%h want lat=%0d res=%h", lat, result, e.lat, e.res);
        else passed++;
        inValid = 1'b1;
        aluControl = 3'd0;
        srcA = 32'd100;
        srcB = 32'd200;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ({outValid, inReady, result, zero} !== {1'b1, 1'b0, e.res, e.z})
                $display("FAIL bp hold cycle %0d: got ov=%b ir=%b res=%h z=%b want 1 0 %h %b",
                         i, outValid, inReady, result, zero, e.res, e.z);
            else passed++;
        end
        inValid = 1'b0;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({outValid, inReady, result} !== {1'b0, 1'b1, e.res})
            $display("FAIL bp release: got ov=%b ir=%b res=%h want 0 1 %h", outValid, inReady, result, e.res);
        else passed++;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   lat;
        outReady = 1'b1;
        send(3'd6, 32'd1, 32'd20);
        repeat (7) @(posedge clk);
        #1;
        void'(sb.pop_back());
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({outValid, result, inReady} !== {1'b0, 32'd0, 1'b1})
            $display("FAIL reset mid-shift: got ov=%b res=%h ir=%b want 0 0 1", outValid, result, inReady);
        else passed++;
        reset = 1'b0;
        send(3'd0, 32'd2, 32'd2);
        waitOut(1'b0, lat);
        e = sb.pop_front();
        total++;
        if ({lat == e.lat, result} !== {1'b1, e.res}) $display("FAIL add after reset: got lat=%0d res=%h want lat=%0d res=%h", lat, result, e.lat, e.res);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_operand_change;
        exp_t e;
        int   lat;
        outReady = 1'b1;
        send(3'd7, 32'hDEAD_BEEF, 32'h0000_0009);
        waitOut(1'b1, lat);
        e = sb.pop_front();
        total++;
        if ({lat == e.lat, result, zero, lessThan} !== {1'b1, e.res, e.z, e.lt})
            $display("FAIL operand change: got lat=%0d res=%h z=%b lt=%b want lat=%0d res=%h z=%b lt=%b",
                     lat, result, zero, lessThan, e.lat, e.res, e.z, e.lt);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   lat;
        outReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 12));
            waitOut(1'b0, lat);
            e = sb.pop_front();
            total++;
            if ({lat == e.lat, result, zero, lessThan} !== {1'b1, e.res, e.z, e.lt})
                $display("FAIL b2b op %0d: got lat=%0d res=%h z=%b lt=%b want lat=%0d res=%h z=%b lt=%b",
                         i, lat, result, zero, lessThan, e.lat, e.res, e.z, e.lt);
            else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_arith;
        test_shift_latency;
        test_backpressure;
        test_reset_mid;
        test_operand_change;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
